// File: rtl/imem_arbiter_pkg.sv
// Shared constants, widths and FSM encoding for the instruction-memory arbiter.
// IMEM_ARB_DBG_WRITE_EN adds the DBG_WR access state.
package imem_arbiter_pkg;

  localparam int unsigned InstAddrBusW     = 32;
  localparam int unsigned InstBusW         = 32;
  localparam int unsigned StarveMaxDefault = 4;

  localparam logic                ChipEnable  = 1'b1;
  localparam logic                ChipDisable = 1'b0;
  localparam logic [InstBusW-1:0] ZeroWord    = '0;

  // Type of access granted in the previous cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCpuRd = 2'd1,
    StDbgRd = 2'd2
`ifdef IMEM_ARB_DBG_WRITE_EN
    ,
    StDbgWr = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// CPU fetch, debug access and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if import imem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = InstAddrBusW
);
  logic                cpu_req;
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_gnt;
  logic                cpu_rvalid;
  logic [InstBusW-1:0] cpu_rdata;

  logic                dbg_req;
  logic                dbg_we;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [InstBusW-1:0] dbg_wdata;
  logic                dbg_gnt;
  logic                dbg_rvalid;
  logic [InstBusW-1:0] dbg_rdata;
  logic                dbg_halt;

  logic                mem_ce;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [InstBusW-1:0] mem_wdata;
  logic [InstBusW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive CPU grants taken while a debug request waits; saturates at STARVE_MAX.
module imem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_gnt_i,
  input  logic dbg_gnt_i,
  input  logic dbg_req_i,
  output logic at_max_o
);
  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req_i || dbg_gnt_i) begin
      cnt_d = '0;
    end else if (cpu_gnt_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CntMax);
endmodule

// File: rtl/imem_arbiter.sv
// Two-master (CPU fetch / debug) arbiter for a single-port instruction memory.
// Debug writes are enabled by defining IMEM_ARB_DBG_WRITE_EN.
module imem_arbiter import imem_arbiter_pkg::*; #(
  parameter int unsigned STARVE_MAX = StarveMaxDefault,
  parameter int unsigned ADDR_W     = InstAddrBusW
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);
  arb_state_e          state_d, state_q;
  logic [InstBusW-1:0] cpu_rdata_d, cpu_rdata_q;
  logic [InstBusW-1:0] dbg_rdata_d, dbg_rdata_q;
  logic                cpu_gnt, dbg_gnt, dbg_wr, starve_max;
  logic [ADDR_W-1:0]   addr_sel;

  imem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .cpu_gnt_i (cpu_gnt),
    .dbg_gnt_i (dbg_gnt),
    .dbg_req_i (bus.dbg_req),
    .at_max_o  (starve_max)
  );

  // Grants are gated by rst so nothing is issued while reset is held.
  always_comb begin
    dbg_gnt = rst & bus.dbg_req & (bus.dbg_halt | ~bus.cpu_req | starve_max);
    cpu_gnt = rst & bus.cpu_req & ~bus.dbg_halt & ~dbg_gnt;
  end

`ifdef IMEM_ARB_DBG_WRITE_EN
  assign dbg_wr = dbg_gnt & bus.dbg_we;
`else
  // Without the write path a debug write is served as a plain read.
  logic unused_dbg_wr;
  assign unused_dbg_wr = ^{bus.dbg_we, bus.dbg_wdata};
  assign dbg_wr        = 1'b0;
`endif

  always_comb begin
    state_d     = StIdle;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (cpu_gnt) begin
      state_d     = StCpuRd;
      cpu_rdata_d = bus.mem_rdata;
    end else if (dbg_gnt) begin
`ifdef IMEM_ARB_DBG_WRITE_EN
      state_d = dbg_wr ? StDbgWr : StDbgRd;
`else
      state_d = StDbgRd;
`endif
      if (!dbg_wr) begin
        dbg_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cpu_rdata_q <= ZeroWord;
      dbg_rdata_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    addr_sel = '0;
    if (dbg_gnt) begin
      addr_sel = bus.dbg_addr;
    end else if (cpu_gnt) begin
      addr_sel = bus.cpu_addr;
    end
  end

  always_comb begin
    bus.cpu_gnt    = cpu_gnt;
    bus.dbg_gnt    = dbg_gnt;
    bus.mem_ce     = (cpu_gnt | dbg_gnt) ? ChipEnable : ChipDisable;
    bus.mem_addr   = addr_sel;
    bus.mem_we     = dbg_wr;
`ifdef IMEM_ARB_DBG_WRITE_EN
    bus.mem_wdata  = dbg_wr ? bus.dbg_wdata : ZeroWord;
`else
    bus.mem_wdata  = ZeroWord;
`endif
    bus.cpu_rvalid = (state_q == StCpuRd);
    bus.dbg_rvalid = (state_q == StDbgRd);
    bus.cpu_rdata  = cpu_rdata_q;
    bus.dbg_rdata  = dbg_rdata_q;
  end
endmodule
